// File: rtl/add_arb_pkg.sv
// Shared types and constants for the shared-adder arbiter.
package add_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int DATA_W = 3;
    localparam int SUM_W  = 4;

    // Round-robin pointer advance: ptr+1, wrapping to 0 at n.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned n);
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/Add.sv
// 3-bit signed adder producing a 4-bit signed sum; cannot overflow.
module Add (
    input  logic [2:0] A,
    input  logic [2:0] B,
    output logic [3:0] C
);

    assign C = {A[2], A} + {B[2], B};

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid request at or above rr_ptr, wrapping.
module rr_picker #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any_valid
);

    logic [ID_W:0] idx;

    // Walk offsets from rr_ptr; the first valid requester found wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(off);
            if (idx >= (ID_W+1)'(N_REQ)) begin
                idx = idx - (ID_W+1)'(N_REQ);
            end
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!any_valid && req[i] && idx == (ID_W+1)'(i)) begin
                    grant[i]  = 1'b1;
                    grant_idx = ID_W'(i);
                    any_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/add_share_arbiter.sv
// Shares one Add instance between N_REQ requesters with round-robin arbitration.
module add_share_arbiter
    import add_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 3,
    parameter int ID_W   = 3,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_W:0]         res_data,
    output logic [ID_W-1:0]         res_id,
    output logic                    busy,
    output logic [N_REQ*CNT_W-1:0]  done_cnt
);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     cur_id_q, cur_id_d;
    logic [ID_W-1:0]     res_id_q, res_id_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [DATA_W:0]     res_data_q, res_data_d;
    logic                res_valid_q, res_valid_d;
    logic [CNT_W-1:0]    done_cnt_q [N_REQ];
    logic [CNT_W-1:0]    done_cnt_d [N_REQ];

    logic [N_REQ-1:0]    pick_grant;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_any;
    logic [N_REQ-1:0]    ready_c;
    logic [SUM_W-1:0]    sum;

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any_valid (pick_any)
    );

    Add u_add (
        .A (op_a_q),
        .B (op_b_q),
        .C (sum)
    );

    // Next-state, operand capture, result latch and counter update.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cur_id_d    = cur_id_q;
        res_id_d    = res_id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        ready_c     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            done_cnt_d[i] = done_cnt_q[i];
        end
        case (state_q)
            IDLE: begin
                ready_c = pick_grant;
                if (pick_any) begin
                    for (int unsigned i = 0; i < N_REQ; i++) begin
                        if (pick_grant[i]) begin
                            op_a_d = req_a[i*DATA_W +: DATA_W];
                            op_b_d = req_b[i*DATA_W +: DATA_W];
                        end
                    end
                    cur_id_d = pick_idx;
                    rr_ptr_d = ID_W'(ptr_inc(32'(pick_idx), N_REQ));
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                res_data_d  = sum;
                res_id_d    = cur_id_q;
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    for (int unsigned i = 0; i < N_REQ; i++) begin
                        if (ID_W'(i) == res_id_q) begin
                            done_cnt_d[i] = done_cnt_q[i] + 1'b1;
                        end
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cur_id_q    <= '0;
            res_id_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                done_cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_id_q    <= cur_id_d;
            res_id_q    <= res_id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                done_cnt_q[i] <= done_cnt_d[i];
            end
        end
    end

    // Pack counters onto the flat output bus.
    always_comb begin
        done_cnt = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            done_cnt[i*CNT_W +: CNT_W] = done_cnt_q[i];
        end
    end

    // Grants are suppressed while reset is held so req_ready reads zero immediately.
    assign req_ready = rst ? '0 : ready_c;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed, table-driven bench for add_share_arbiter.
module tb_add_share_arbiter;

    localparam int N  = 2;
    localparam int CW = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*3-1:0] req_a = '0;
    logic [N*3-1:0] req_b = '0;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [3:0]     res_data;
    logic [2:0]     res_id;
    logic           busy;
    logic [N*CW-1:0] done_cnt;

    int total = 0;
    int bad   = 0;
    logic [CW-1:0] exp_cnt [N];

    typedef struct {
        int         id;
        logic [2:0] a;
        logic [2:0] b;
        logic [3:0] exp;
        int         stall;
    } vec_t;

    vec_t vecs [6];

    add_share_arbiter #(
        .N_REQ  (N),
        .DATA_W (3),
        .ID_W   (3),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < N; i++) exp_cnt[i] = '0;
    endtask

    task automatic wait_grant(input int id);
        int w;
        w = 0;
        #1;
        while (req_ready[id] !== 1'b1 && w < 20) begin
            @(posedge clk); #2;
            w++;
        end
        check("grant_timeout", (w < 20) ? 1 : 0, 1);
        check("grant_onehot", req_ready, 32'(1) << id);
    endtask

    // One full transaction on requester id, with optional back-pressure cycles.
    task automatic run_op(input int id, input logic [2:0] a, input logic [2:0] b,
                          input logic [3:0] exp, input int stall);
        req_valid[id] = 1'b1;
        req_a[id*3 +: 3] = a;
        req_b[id*3 +: 3] = b;
        wait_grant(id);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        req_a[id*3 +: 3] = ~a;
        req_b[id*3 +: 3] = ~b;
        check("issue_valid", res_valid, 0);
        check("issue_busy", busy, 1);
        check("issue_ready", req_ready, 0);
        @(posedge clk); #1;
        check("res_valid", res_valid, 1);
        check("res_data", res_data, exp);
        check("res_id", res_id, id);
        for (int s = 0; s < stall; s++) begin
            res_ready = 1'b0;
            @(posedge clk); #1;
            check("stall_valid", res_valid, 1);
            check("stall_data", res_data, exp);
            check("stall_id", res_id, id);
            check("stall_ready", req_ready, 0);
            check("stall_cnt", done_cnt[id*CW +: CW], exp_cnt[id]);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        exp_cnt[id] = exp_cnt[id] + 1'b1;
        check("done_valid", res_valid, 0);
        check("done_busy", busy, 0);
        check("done_cnt", done_cnt[id*CW +: CW], exp_cnt[id]);
    endtask

    initial begin
        vecs[0] = '{id: 0, a: 3'b011, b: 3'b010, exp: 4'b0101, stall: 0};
        vecs[1] = '{id: 0, a: 3'b100, b: 3'b100, exp: 4'b1000, stall: 0};
        vecs[2] = '{id: 0, a: 3'b011, b: 3'b100, exp: 4'b1111, stall: 0};
        vecs[3] = '{id: 0, a: 3'b101, b: 3'b011, exp: 4'b0000, stall: 0};
        vecs[4] = '{id: 1, a: 3'b011, b: 3'b011, exp: 4'b0110, stall: 0};
        vecs[5] = '{id: 1, a: 3'b111, b: 3'b111, exp: 4'b1110, stall: 2};
        for (int i = 0; i < N; i++) exp_cnt[i] = '0;

        // Reset state, with a request asserted during reset.
        req_valid = 2'b01;
        #2;
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_id", res_id, 0);
        check("rst_done_cnt", done_cnt, 0);
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", busy, 0);

        // Table-driven single-requester vectors.
        for (int v = 0; v < 6; v++) begin
            run_op(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].exp, vecs[v].stall);
        end

        // Back-pressure with req1 pending; rr_ptr is 0 here so req0 wins.
        req_valid[1] = 1'b1;
        req_a[3 +: 3] = 3'b001;
        req_b[3 +: 3] = 3'b010;
        run_op(0, 3'b010, 3'b001, 4'b0011, 5);
        run_op(1, 3'b001, 3'b010, 4'b0011, 0);

        // Asynchronous reset while a result is held.
        req_valid[0] = 1'b1;
        req_a[0 +: 3] = 3'b001;
        req_b[0 +: 3] = 3'b001;
        wait_grant(0);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        check("pre_rst_valid", res_valid, 1);
        check("pre_rst_cnt", done_cnt, {exp_cnt[1], exp_cnt[0]});
        rst = 1'b1;
        #1;
        check("async_rst_valid", res_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_cnt", done_cnt, 0);
        check("async_rst_data", res_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < N; i++) exp_cnt[i] = '0;
        @(posedge clk); #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", res_valid, 0);

        // Contention: both held valid from rr_ptr=0 -> grants 0,1,0,1.
        req_valid = 2'b11;
        req_a = {3'b010, 3'b001};
        req_b = {3'b111, 3'b001};
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int eid;
            eid = k % 2;
            wait_grant(eid);
            @(posedge clk); #1;
            if (k == 3) req_valid = '0;
            @(posedge clk); #1;
            check("cont_valid", res_valid, 1);
            check("cont_id", res_id, eid);
            check("cont_data", res_data, (eid == 0) ? 4'b0010 : 4'b0001);
            @(posedge clk); #1;
            exp_cnt[eid] = exp_cnt[eid] + 1'b1;
            check("cont_cnt", done_cnt[eid*CW +: CW], exp_cnt[eid]);
        end
        res_ready = 1'b0;
        check("cont_cnt0", done_cnt[0 +: CW], 2);
        check("cont_cnt1", done_cnt[CW +: CW], 2);

        // Counter wrap on requester 1; requester 0 keeps its count.
        do_reset();
        run_op(0, 3'b001, 3'b000, 4'b0001, 0);
        for (int n = 0; n < 256; n++) begin
            run_op(1, 3'b110, 3'b001, 4'b1111, 0);
        end
        check("wrap_cnt1", done_cnt[CW +: CW], 0);
        check("wrap_cnt0", done_cnt[0 +: CW], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/add_share_arbiter.md
Name: add_share_arbiter

Overview:
- Shares one instance of the existing 3-bit signed `Add` module between N_REQ requesters.
- Each requester presents A/B operands over a valid/ready handshake.
- A round-robin arbiter grants one request at a time and sequences the operands through the adder.
- The registered 4-bit sum is returned with the requester ID on a valid/ready result channel; per-requester completion counters are kept.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DATA_W, 3, operand width; fixed at 3 to match `Add`.
- ID_W, 3, width of the requester index field (must satisfy 2^ID_W >= N_REQ).
- CNT_W, 8, width of each completion counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester grant/accept, one-hot or zero.
- req_a  in  N_REQ*DATA_W  signed operand A per requester; requester i uses bits [i*3+:3].
- req_b  in  N_REQ*DATA_W  signed operand B per requester, same packing as req_a.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts the result.
- res_data  out  DATA_W+1  signed sum.
- res_id  out  ID_W  index of the requester that owns res_data.
- busy  out  1  high whenever state != IDLE.
- done_cnt  out  N_REQ*CNT_W  per-requester completed-result counters, wrapping.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; res_valid=0; res_data=0; res_id=0; rr_ptr=0; all done_cnt=0; req_ready=0; busy=0. Reset mid-operation discards the in-flight request and any held result; no counter update.
- FSM states: IDLE, ISSUE, HOLD.
- IDLE:
  - req_ready is combinational: a one-hot on the first index i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo N_REQ.
  - req_ready is all zero if no request is valid.
  - On a grant g: capture op_a=req_a[g], op_b=req_b[g], cur_id=g; rr_ptr <= (g+1) mod N_REQ; next state ISSUE.
  - With no valid request, stay in IDLE; rr_ptr is unchanged.
- ISSUE:
  - `Add` sees op_a/op_b.
  - res_data <= C; res_id <= cur_id; res_valid <= 1; next state HOLD.
  - req_ready=0.
- HOLD:
  - res_valid=1; res_data and res_id held stable.
  - When res_ready=1: res_valid <= 0; done_cnt[res_id] += 1, wrapping from 2^CNT_W-1 to 0; next state IDLE.
  - Otherwise stay in HOLD.
  - req_ready=0.
- Latency: with the grant in cycle T, res_valid rises at the edge ending T+1 and is visible in T+2. Minimum 3 cycles per operation, assuming res_ready is held high.
- Arithmetic:
  - C = sign-extend(A) + sign-extend(B), 4-bit signed.
  - Full input range is -4..3, so the result range is -8..6; no overflow is possible and no saturation is applied.
- Requester rules:
  - A requester must hold req_valid and its operands stable until it sees req_ready.
  - Dropping req_valid before the grant is legal; nothing is recorded.
  - Operands changing after the grant do not affect the captured result.
- Simultaneous requests: exactly one grant per IDLE cycle. Fairness: a continuously requesting requester waits at most N_REQ-1 other grants.
- res_ready=1 outside HOLD is ignored.

Decomposition:
- Package add_arb_pkg:
  - state enum {IDLE, ISSUE, HOLD};
  - DATA_W=3 and SUM_W=4 constants;
  - a helper function for the modulo-N pointer increment.
- Sub-module rr_picker: combinational round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, encoded index, any_valid.
- The arbiter instantiates `Add` directly (ports A, B, C).

Test Plan:
- Reset with rst=1 mid-HOLD (res_valid=1) -> res_valid, busy, and all done_cnt drop to 0 immediately, without waiting for a clock edge; after release the FSM sits in IDLE.
- Single request: req0 A=3, B=2, res_ready=1 -> req_ready[0] in cycle T, res_valid in T+2 with res_data=5, res_id=0; done_cnt[0]=1.
- Extremes: A=-4, B=-4 -> res_data=-8 (4'b1000); then A=3, B=-4 -> -1; then A=-3, B=3 -> 0.
- Contention: req0 and req1 both held valid with rr_ptr=0 and four ops -> grant order 0,1,0,1; res_id sequence matches; done_cnt = 2 and 2.
- Back-pressure: res_ready=0 for 5 cycles in HOLD -> res_data/res_id stable, req_ready stays 0 despite pending req1; the counter increments only on the ready cycle.
- Counter wrap: 256 completions on req1 -> done_cnt[1] returns to 0; done_cnt[0] is unaffected.
